// File: rtl/cfg_reg_arbiter_pkg.sv
// cfg_reg_arbiter_pkg: op codes and FSM state encodings shared by the config-register arbiter
package cfg_reg_arbiter_pkg;
  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_CLR     = 2'b10,
    OP_CLR_ALL = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_EXEC  = 2'b10,
    S_ACK   = 2'b11
  } state_e;
endpackage

// File: rtl/cfg_reg_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last granted requester
//   i_req       request vector
//   i_last      index of the previously granted requester
//   o_grant     one-hot winner
//   o_grant_idx winner index
//   o_valid     any request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_valid
);
  int j;
  // Walk the search order backwards so the requester closest after i_last wins.
  always_comb begin
    o_grant_idx = '0;
    o_valid = 1'b0;
    j = 0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(i_last) + i) % N;
      if (i_req[IW'(j)]) begin
        o_grant_idx = IW'(j);
        o_valid = 1'b1;
      end
    end
  end
  assign o_grant = o_valid ? (N'(1) << o_grant_idx) : '0;
endmodule

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter: round-robin shared access to a bank of config registers
//   i_clk, i_arst_n  clock, async active-low reset
//   i_req/i_op/i_addr/i_wdata  per-requester flat request fields
//   o_ack    one-cycle completion pulse to the granted requester
//   o_err    address out of range (valid with o_ack)
//   o_rdata  read data (valid with o_ack)
//   o_busy   FSM not idle
//   o_regs   flat bank contents
module cfg_reg_arbiter
  import cfg_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_arst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [2*NUM_REQ-1:0]           i_op,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  i_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  i_wdata,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic                           o_err,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic                           o_busy,
  output logic [DATA_WIDTH*NUM_REGS-1:0] o_regs
);
  localparam int IW = $clog2(NUM_REQ);
  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [IW-1:0]          last_q, last_d, g_idx;
  logic [NUM_REQ-1:0]     g_onehot;
  logic                   g_valid, err_q, err_d, oob, exec;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, rd;
  logic [NUM_REGS-1:0]    wr, clr;
  logic [DATA_WIDTH-1:0]  bank_q [NUM_REGS];
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req       (i_req),
    .i_last      (last_q),
    .o_grant     (g_onehot),
    .o_grant_idx (g_idx),
    .o_valid     (g_valid)
  );
  // Extra top bit keeps the compare correct when NUM_REGS == 2**ADDR_WIDTH.
  assign oob  = {1'b0, addr_q} >= (ADDR_WIDTH+1)'(NUM_REGS);
  assign exec = state_q == S_EXEC;
  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (addr_q == ADDR_WIDTH'(k)) rd = bank_q[k];
  end
  always_comb begin
    state_d = state_q == S_IDLE  ? (|i_req ? S_GRANT : S_IDLE) :
              state_q == S_GRANT ? (g_valid ? S_EXEC : S_IDLE) :
              state_q == S_EXEC  ? S_ACK : S_IDLE;
    last_d  = last_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (state_q == S_GRANT && g_valid) begin
      last_d = g_idx;
      for (int r = 0; r < NUM_REQ; r++)
        if (g_onehot[r]) begin
          op_d    = op_e'(i_op[2*r +: 2]);
          addr_d  = i_addr[ADDR_WIDTH*r +: ADDR_WIDTH];
          wdata_d = i_wdata[DATA_WIDTH*r +: DATA_WIDTH];
        end
    end
    if (exec) begin
      err_d   = op_q != OP_CLR_ALL && oob;
      rdata_d = (op_q == OP_READ && !oob) ? rd : '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_REQ-1);
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_bank
    assign wr[k]  = exec && op_q == OP_WRITE && addr_q == ADDR_WIDTH'(k);
    assign clr[k] = exec && (op_q == OP_CLR_ALL || (op_q == OP_CLR && addr_q == ADDR_WIDTH'(k)));
    always_ff @(posedge i_clk or negedge i_arst_n)
      if (!i_arst_n) bank_q[k] <= '0;
      else if (clr[k]) bank_q[k] <= '0;
      else if (wr[k]) bank_q[k] <= wdata_q;
    assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = bank_q[k];
  end
  assign o_ack   = state_q == S_ACK ? (NUM_REQ'(1) << last_q) : '0;
  assign o_err   = state_q == S_ACK && err_q;
  assign o_rdata = state_q == S_ACK ? rdata_q : '0;
  assign o_busy  = state_q != S_IDLE;
endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb_cfg_reg_arbiter: directed self-checking bench for cfg_reg_arbiter
module tb_cfg_reg_arbiter;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [3:0]  op = '0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  ack;
  logic        err, busy;
  logic [7:0]  rdata;
  logic [63:0] regs;
  int n_chk = 0;
  int n_fail = 0;
  cfg_reg_arbiter #(.NUM_REQ(2), .NUM_REGS(8), .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .i_req    (req),
    .i_op     (op),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_ack    (ack),
    .o_err    (err),
    .o_rdata  (rdata),
    .o_busy   (busy),
    .o_regs   (regs)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input int r, input logic [1:0] o, input logic [3:0] a, input logic [7:0] d);
    op[2*r +: 2]    = o;
    addr[4*r +: 4]  = a;
    wdata[8*r +: 8] = d;
    req[r]          = 1'b1;
  endtask
  initial begin
    tick(2);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_regs", regs, 0);
    arst_n = 1'b1;
    tick(1);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_err", 64'(err), 0);
    chk("idle_rdata", 64'(rdata), 0);
    // 1: write req0 addr2 = A5, ack three cycles later
    issue(0, 2'b01, 4'd2, 8'hA5);
    tick(1);
    chk("w_grant_busy", 64'(busy), 1);
    chk("w_grant_ack", 64'(ack), 0);
    tick(1);
    chk("w_exec_ack", 64'(ack), 0);
    tick(1);
    chk("w_ack", 64'(ack), 2'b01);
    chk("w_err", 64'(err), 0);
    chk("w_regs", regs, 64'h0000_0000_00A5_0000);
    req = '0;
    tick(1);
    chk("w_after_ack", 64'(ack), 0);
    chk("w_after_busy", 64'(busy), 0);
    // 2: read req1 addr2
    issue(1, 2'b00, 4'd2, 8'hFF);
    tick(3);
    chk("r_ack", 64'(ack), 2'b10);
    chk("r_rdata", 64'(rdata), 8'hA5);
    chk("r_regs", regs, 64'h0000_0000_00A5_0000);
    req = '0;
    tick(1);
    // 3: both held high, grants alternate 0,1,0,1 every 4 cycles
    issue(0, 2'b01, 4'd0, 8'h10);
    issue(1, 2'b01, 4'd1, 8'h20);
    tick(3);
    chk("rr0_ack", 64'(ack), 2'b01);
    tick(3);
    chk("rr1_gap", 64'(ack), 0);
    tick(1);
    chk("rr1_ack", 64'(ack), 2'b10);
    tick(4);
    chk("rr2_ack", 64'(ack), 2'b01);
    tick(4);
    chk("rr3_ack", 64'(ack), 2'b10);
    req = '0;
    tick(1);
    chk("rr_regs", regs, 64'h0000_0000_00A5_2010);
    // 4: out-of-range write
    issue(0, 2'b01, 4'd9, 8'hFF);
    tick(3);
    chk("oob_ack", 64'(ack), 2'b01);
    chk("oob_err", 64'(err), 1);
    chk("oob_rdata", 64'(rdata), 0);
    chk("oob_regs", regs, 64'h0000_0000_00A5_2010);
    req = '0;
    tick(1);
    // 5: fill, clear one, clear all
    for (int i = 0; i < 8; i++) begin
      issue(0, 2'b01, 4'(i), 8'((i + 1) * 8'h11));
      tick(3);
      chk("fill_ack", 64'(ack), 2'b01);
      req = '0;
      tick(1);
    end
    chk("fill_regs", regs, 64'h8877_6655_4433_2211);
    issue(1, 2'b10, 4'd3, 8'h00);
    tick(3);
    chk("clr_ack", 64'(ack), 2'b10);
    chk("clr_regs", regs, 64'h8877_6655_0033_2211);
    req = '0;
    tick(1);
    issue(0, 2'b11, 4'd9, 8'h00);
    tick(3);
    chk("clra_ack", 64'(ack), 2'b01);
    chk("clra_err", 64'(err), 0);
    chk("clra_regs", regs, 0);
    req = '0;
    tick(1);
    // 6: reset during EXEC of a write
    issue(0, 2'b01, 4'd5, 8'h3C);
    tick(2);
    chk("rx_exec_busy", 64'(busy), 1);
    arst_n = 1'b0;
    #1;
    chk("rx_busy", 64'(busy), 0);
    chk("rx_ack", 64'(ack), 0);
    req = '0;
    tick(1);
    arst_n = 1'b1;
    tick(1);
    chk("rx_post_busy", 64'(busy), 0);
    chk("rx_post_ack", 64'(ack), 0);
    chk("rx_post_regs", regs, 0);
    // pointer restarts at requester 0
    issue(0, 2'b01, 4'd0, 8'h01);
    issue(1, 2'b01, 4'd1, 8'h02);
    tick(3);
    chk("ptr_ack", 64'(ack), 2'b01);
    req = '0;
    tick(1);
    // dropping req after grant still completes the op
    issue(1, 2'b01, 4'd6, 8'h77);
    tick(2);
    req = '0;
    tick(1);
    chk("drop_ack", 64'(ack), 2'b10);
    chk("drop_regs", regs, 64'h0077_0000_0000_0001);
    tick(1);
    chk("drop_idle", 64'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
